// File: rtl/seq_divider_if.sv
// Request/response bundle between the execute stage and the iterative divider.
// The execute stage drives the master side; the divider implements the slave side.
interface seq_divider_if #(
    parameter int unsigned XLEN = 32
);
    logic            valid;
    logic            ready;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            kill;
    logic [XLEN-1:0] result;
    logic            done;

    modport master (
        output valid, op, a, b, kill,
        input  ready, result, done
    );

    modport slave (
        input  valid, op, a, b, kill,
        output ready, result, done
    );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// It works on operand magnitudes and applies the sign correction in a final FIX cycle.
module seq_divider #(
    parameter int unsigned XLEN = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    seq_divider_if.slave  div_io
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [5:0]      cnt_q, cnt_d;
    logic            is_rem_q, is_rem_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            done_q, done_d;

    logic            accept;
    logic            is_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, sgn_ovf;
    logic [XLEN:0]   shifted, diff;
    logic [XLEN-1:0] quo_fixed, rem_fixed;

    assign accept    = div_io.valid & (state_q == StIdle) & ~div_io.kill;
    assign is_signed = ~div_io.op[0];
    assign a_neg     = is_signed & div_io.a[XLEN-1];
    assign b_neg     = is_signed & div_io.b[XLEN-1];
    assign a_mag     = a_neg ? -div_io.a : div_io.a;
    assign b_mag     = b_neg ? -div_io.b : div_io.b;
    assign div_zero  = (div_io.b == '0);
    assign sgn_ovf   = is_signed & (div_io.a == {1'b1, {(XLEN-1){1'b0}}}) & (div_io.b == '1);

    // The 33-bit trial subtract keeps a magnitude of 2^31 (and unsigned 2^32-1) exact.
    assign shifted   = {rem_q, quo_q[XLEN-1]};
    assign diff      = shifted - {1'b0, dvs_q};
    assign quo_fixed = neg_quo_q ? -quo_q : quo_q;
    assign rem_fixed = neg_rem_q ? -rem_q : rem_q;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    is_rem_d = div_io.op[1];
                    cnt_d    = '0;
                    dvs_d    = b_mag;
                    if (div_zero) begin
                        // Special results are loaded raw; clearing the sign flags bypasses FIX negation.
                        quo_d     = '1;
                        rem_d     = div_io.a;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = StFix;
                    end else if (sgn_ovf) begin
                        quo_d     = {1'b1, {(XLEN-1){1'b0}}};
                        rem_d     = '0;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = StFix;
                    end else begin
                        quo_d     = a_mag;
                        rem_d     = '0;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        state_d   = StCalc;
                    end
                end
            end
            StCalc: begin
                if (!diff[XLEN]) begin
                    rem_d = diff[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = shifted[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(XLEN - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                res_d   = is_rem_q ? rem_fixed : quo_fixed;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (div_io.kill) begin
            state_d = StIdle;
            done_d  = 1'b0;
            res_d   = res_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            res_q     <= res_d;
            cnt_q     <= cnt_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
        end
    end

    assign div_io.ready  = (state_q == StIdle);
    assign div_io.done   = done_q;
    assign div_io.result = res_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed RV32M cases, kill/reset scenarios and random ops
// checked against an arithmetic reference model, including result latency.
module tb_seq_divider;

    logic clk;
    logic rst_ni;
    int   cyc;

    seq_divider_if #(.XLEN(32)) dif ();

    seq_divider #(.XLEN(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .div_io (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          checks;
    int          errors;
    logic [31:0] last_res;
    int          last_done_cyc;

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (!op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_ni && dif.done === 1'b1) begin
                last_done_cyc = cyc;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got done_o=1 at cycle %0d, expected none", cyc);
                end else begin
                    e = sb_q.pop_front();
                    last_res = e.res;
                    check32("result", dif.result, e.res);
                    check32("latency", 32'(cyc - e.acc), 32'(e.lat));
                end
            end
        end
    endtask

    // Starts and ends on a falling edge; returns the edge count of the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, output int acc);
        int   n;
        exp_t e;
        dif.valid = 1'b1;
        dif.op    = op;
        dif.a     = a;
        dif.b     = b;
        n = 0;
        while (dif.ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        acc = -1;
        if (dif.ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready_o=%b, expected 1 within 100 cycles", dif.ready);
            dif.valid = 1'b0;
        end else begin
            @(negedge clk);
            dif.valid = 1'b0;
            acc = cyc;
            if (push) begin
                e.res = model(op, a, b);
                e.acc = acc;
                e.lat = model_lat(op, a, b);
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check32("drain_pending", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    vec_t dir[] = '{
        '{2'b00, 32'd100,        32'd7},
        '{2'b10, 32'd100,        32'd7},
        '{2'b10, 32'hFFFF_FF9C,  32'd7},
        '{2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9},
        '{2'b01, 32'hFFFF_FFFF,  32'd1},
        '{2'b01, 32'h0000_1234,  32'd0},
        '{2'b11, 32'h0000_1234,  32'd0},
        '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF},
        '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF},
        '{2'b00, 32'hFFFF_FF9C,  32'd0},
        '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF},
        '{2'b00, 32'h8000_0000,  32'd1}
    };

    initial begin
        int          acc, acc2, n;
        logic [1:0]  op;
        logic [31:0] a, b;

        checks        = 0;
        errors        = 0;
        last_res      = 32'd0;
        last_done_cyc = -1;
        rst_ni        = 1'b0;
        dif.valid     = 1'b0;
        dif.kill      = 1'b0;
        dif.op        = 2'b00;
        dif.a         = 32'd0;
        dif.b         = 32'd0;

        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check32("reset_ready", 32'(dif.ready), 32'd1);
        check32("reset_done", 32'(dif.done), 32'd0);
        check32("reset_result", dif.result, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk);

        // Kill while idle must block acceptance.
        dif.valid = 1'b1;
        dif.kill  = 1'b1;
        dif.op    = 2'b01;
        dif.a     = 32'd9;
        dif.b     = 32'd3;
        @(negedge clk);
        dif.valid = 1'b0;
        dif.kill  = 1'b0;
        check32("idle_kill_ready", 32'(dif.ready), 32'd1);
        repeat (3) @(negedge clk);

        foreach (dir[i]) issue(dir[i].op, dir[i].a, dir[i].b, 1'b1, acc);
        drain();

        // Kill in the 10th CALC cycle.
        issue(2'b00, 32'd100, 32'd7, 1'b0, acc);
        repeat (9) @(negedge clk);
        dif.kill = 1'b1;
        @(negedge clk);
        dif.kill = 1'b0;
        check32("kill_ready", 32'(dif.ready), 32'd1);
        check32("kill_done", 32'(dif.done), 32'd0);
        check32("kill_result_held", dif.result, last_res);
        repeat (40) @(negedge clk);
        issue(2'b01, 32'd50, 32'd5, 1'b1, acc);
        drain();

        // Asynchronous reset in the 20th CALC cycle.
        issue(2'b00, 32'd100, 32'd7, 1'b0, acc);
        repeat (19) @(negedge clk);
        #2 rst_ni = 1'b0;
        #1;
        check32("arst_ready", 32'(dif.ready), 32'd1);
        check32("arst_done", 32'(dif.done), 32'd0);
        check32("arst_result", dif.result, 32'd0);
        last_res = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (40) @(negedge clk);
        issue(2'b11, 32'd17, 32'd5, 1'b1, acc);
        issue(2'b01, 32'd17, 32'd5, 1'b1, acc2);
        check32("b2b_accept_gap", 32'(acc2 - acc), 32'd34);
        drain();
        check32("b2b_accept_on_done", 32'(acc2 + 33), 32'(last_done_cyc));

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            n  = $urandom_range(0, 9);
            case (n)
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 15));
                3: begin
                    a = 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                end
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            issue(op, a, b, 1'b1, acc);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
